// File: rtl/dm_sba_arbiter_pkg.sv
// dm_sba_arbiter_pkg: shared constants and helpers for the SBA bus arbiter
package dm_sba_arbiter_pkg;
  localparam int unsigned DefaultMaxOutstanding = 2;
  function automatic int unsigned idx_width(input int unsigned n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/dm_sba_id_fifo.sv
// dm_sba_id_fifo: in-order FIFO of requester indices for outstanding bus transactions
module dm_sba_id_fifo #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] data_in,
  output logic [Width-1:0] data_out,
  output logic             empty,
  output logic             full
);
  localparam int unsigned PtrW = Depth > 1 ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);
  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_q, rd_q;
  logic [CntW-1:0]  cnt_q;
  logic             do_push, do_pop;
  assign empty    = cnt_q == '0;
  assign full     = cnt_q == CntW'(Depth);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign data_out = mem[rd_q];
  // storage is not reset; validity is tracked by the count
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_q] <= data_in;
  end
  // pointers and occupancy, cleared by reset or flush
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q == PtrW'(Depth - 1) ? '0 : wr_q + 1'b1;
      if (do_pop) rd_q <= rd_q == PtrW'(Depth - 1) ? '0 : rd_q + 1'b1;
      cnt_q <= cnt_q + CntW'(do_push) - CntW'(do_pop);
    end
  end
endmodule

// File: rtl/dm_sba_arbiter.sv
// dm_sba_arbiter: round-robin sharing of one in-order bus master port among requesters
module dm_sba_arbiter
  import dm_sba_arbiter_pkg::*;
#(
  parameter int unsigned NumReq         = 2,
  parameter int unsigned BusWidth       = 32,
  parameter int unsigned MaxOutstanding = DefaultMaxOutstanding
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 dmactive_i,
  input  logic [NumReq-1:0]                    req_i,
  input  logic [NumReq-1:0][BusWidth-1:0]      add_i,
  input  logic [NumReq-1:0]                    we_i,
  input  logic [NumReq-1:0][BusWidth-1:0]      wdata_i,
  input  logic [NumReq-1:0][BusWidth/8-1:0]    be_i,
  output logic [NumReq-1:0]                    gnt_o,
  output logic [NumReq-1:0]                    r_valid_o,
  output logic [BusWidth-1:0]                  r_rdata_o,
  output logic                                 master_req_o,
  output logic [BusWidth-1:0]                  master_add_o,
  output logic                                 master_we_o,
  output logic [BusWidth-1:0]                  master_wdata_o,
  output logic [BusWidth/8-1:0]                master_be_o,
  input  logic                                 master_gnt_i,
  input  logic                                 master_r_valid_i,
  input  logic [BusWidth-1:0]                  master_r_rdata_i,
  output logic                                 rsp_err_o
);
  localparam int unsigned IdxW = idx_width(NumReq);
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  typedef logic [IdxW-1:0] sba_rr_idx_t;
  sba_rr_idx_t     rr_q, lock_idx_q, rr_sel, sel, head, cand;
  logic            lock_q, hit, full, hs, pop, fifo_empty, fifo_full;
  logic [CntW-1:0] count_q;
  // first requesting index at or after the round-robin pointer, with wrap-around
  always_comb begin
    rr_sel = rr_q;
    hit    = 1'b0;
    cand   = rr_q;
    for (int k = 0; k < NumReq; k++) begin
      cand = IdxW'((int'(rr_q) + k) % NumReq);
      if (!hit && req_i[cand]) begin
        rr_sel = cand;
        hit    = 1'b1;
      end
    end
  end
  assign sel            = lock_q ? lock_idx_q : rr_sel;
  assign full           = count_q == CntW'(MaxOutstanding);
  assign master_req_o   = req_i[sel] & ~full & dmactive_i & rst_ni;
  assign master_add_o   = add_i[sel];
  assign master_we_o    = we_i[sel] & rst_ni;
  assign master_wdata_o = wdata_i[sel];
  assign master_be_o    = be_i[sel];
  assign hs             = master_req_o & master_gnt_i;
  assign gnt_o          = hs ? (NumReq'(1) << sel) : '0;
  assign pop            = master_r_valid_i & ~fifo_empty & dmactive_i & rst_ni;
  assign r_valid_o      = pop ? (NumReq'(1) << head) : '0;
  assign r_rdata_o      = master_r_rdata_i;
  assign rsp_err_o      = master_r_valid_i & rst_ni & ~pop;
  dm_sba_id_fifo #(
    .Depth(MaxOutstanding),
    .Width(IdxW)
  ) i_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush   (~dmactive_i),
    .push    (hs),
    .pop     (pop),
    .data_in (sel),
    .data_out(head),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );
  // round-robin pointer, grant lock and outstanding count
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      count_q    <= '0;
    end else if (!dmactive_i) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      count_q    <= '0;
    end else begin
      if (hs) rr_q <= sel == IdxW'(NumReq - 1) ? '0 : sel + 1'b1;
      if (hs) lock_q <= 1'b0;
      else if (master_req_o) begin
        lock_q     <= 1'b1;
        lock_idx_q <= sel;
      end
      count_q <= count_q + CntW'(hs) - CntW'(pop);
    end
  end
  a_hold_req: assert property (@(posedge clk_i) disable iff (!rst_ni || !dmactive_i)
    lock_q |-> req_i[lock_idx_q]);
  a_fifo_cnt: assert property (@(posedge clk_i) disable iff (!rst_ni)
    fifo_full == full);
endmodule

// File: tb/tb_dm_sba_arbiter.sv
// tb_dm_sba_arbiter: scoreboard bench for the SBA bus arbiter
module tb_dm_sba_arbiter;
  logic             clk_i = 1'b0;
  logic             rst_ni, dmactive_i;
  logic [1:0]       req_i, we_i, gnt_o, r_valid_o;
  logic [1:0][31:0] add_i, wdata_i;
  logic [1:0][3:0]  be_i;
  logic [31:0]      r_rdata_o, master_add_o, master_wdata_o, master_r_rdata_i;
  logic [3:0]       master_be_o;
  logic             master_req_o, master_we_o, master_gnt_i, master_r_valid_i, rsp_err_o;
  int               total = 0, bad = 0;
  logic [63:0]      qg[$], qr[$];

  dm_sba_arbiter #(.NumReq(2), .BusWidth(32), .MaxOutstanding(2)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .dmactive_i(dmactive_i),
    .req_i(req_i), .add_i(add_i), .we_i(we_i), .wdata_i(wdata_i), .be_i(be_i),
    .gnt_o(gnt_o), .r_valid_o(r_valid_o), .r_rdata_o(r_rdata_o),
    .master_req_o(master_req_o), .master_add_o(master_add_o), .master_we_o(master_we_o),
    .master_wdata_o(master_wdata_o), .master_be_o(master_be_o),
    .master_gnt_i(master_gnt_i), .master_r_valid_i(master_r_valid_i),
    .master_r_rdata_i(master_r_rdata_i), .rsp_err_o(rsp_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic neg;
    @(negedge clk_i);
  endtask

  task automatic exp_g(input logic [1:0] v, input logic [31:0] a);
    qg.push_back({30'b0, v, a});
  endtask

  task automatic exp_r(input logic [1:0] v, input logic e, input logic [31:0] d);
    qr.push_back({29'b0, v, e, d});
  endtask

  // monitor: every grant or response the DUT presents is matched against the scoreboard
  always @(negedge clk_i) begin
    if (gnt_o != 2'b00) begin
      if (qg.size() == 0) begin
        total++;
        bad++;
        $display("FAIL gnt_unexpected: got gnt=%b expected none", gnt_o);
      end else chk("gnt", {30'b0, gnt_o, master_add_o}, qg.pop_front());
    end
    if (r_valid_o != 2'b00 || rsp_err_o) begin
      if (qr.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rsp_unexpected: got r_valid=%b err=%b expected none", r_valid_o, rsp_err_o);
      end else chk("rsp", {29'b0, r_valid_o, rsp_err_o, r_rdata_o}, qr.pop_front());
    end
  end

  initial begin
    rst_ni = 1'b0; dmactive_i = 1'b1; req_i = 2'b11; we_i = 2'b11;
    add_i[0] = 32'h1000; add_i[1] = 32'h2000;
    wdata_i[0] = 32'hAAAA0000; wdata_i[1] = 32'hBBBB0000;
    be_i[0] = 4'h3; be_i[1] = 4'hC;
    master_gnt_i = 1'b1; master_r_valid_i = 1'b1; master_r_rdata_i = 32'h55;
    neg;
    chk("rst_req", master_req_o, 0);
    chk("rst_gnt", gnt_o, 0);
    chk("rst_rvalid", r_valid_o, 0);
    chk("rst_err", rsp_err_o, 0);
    chk("rst_we", master_we_o, 0);
    chk("rst_add", master_add_o, 32'h1000);
    chk("rst_wdata", master_wdata_o, 32'hAAAA0000);
    chk("rst_be", master_be_o, 4'h3);
    tick;
    req_i = 2'b00; we_i = 2'b00; master_gnt_i = 1'b0; master_r_valid_i = 1'b0; rst_ni = 1'b1;
    tick;
    // single request stalled two cycles, then granted and answered
    req_i = 2'b01;
    neg; chk("s1_req", master_req_o, 1); chk("s1_add_c1", master_add_o, 32'h1000);
    tick;
    neg; chk("s1_add_c2", master_add_o, 32'h1000);
    tick;
    master_gnt_i = 1'b1; exp_g(2'b01, 32'h1000);
    neg; chk("s1_add_c3", master_add_o, 32'h1000);
    tick;
    req_i = 2'b00; master_gnt_i = 1'b0;
    master_r_valid_i = 1'b1; master_r_rdata_i = 32'hDEADBEEF; exp_r(2'b01, 1'b0, 32'hDEADBEEF);
    tick;
    master_r_valid_i = 1'b0;
    // round robin with both requesting; pointer sits at 1 after the previous grant
    req_i = 2'b11; master_gnt_i = 1'b1; add_i[0] = 32'h3000; add_i[1] = 32'h4000;
    for (int k = 0; k < 4; k++) begin
      exp_g(k % 2 == 0 ? 2'b10 : 2'b01, k % 2 == 0 ? 32'h4000 : 32'h3000);
      master_r_valid_i = k > 0;
      master_r_rdata_i = 32'(32'hC0DE0000 + k - 1);
      if (k > 0) exp_r(k % 2 == 1 ? 2'b10 : 2'b01, 1'b0, 32'(32'hC0DE0000 + k - 1));
      tick;
    end
    req_i = 2'b00; master_gnt_i = 1'b0;
    master_r_valid_i = 1'b1; master_r_rdata_i = 32'hC0DE0003; exp_r(2'b01, 1'b0, 32'hC0DE0003);
    tick;
    master_r_valid_i = 1'b0;
    // lock: requester 0 stalls, requester 1 arrives while pointer favours it
    req_i = 2'b01;
    neg; chk("s3_add_pre", master_add_o, 32'h3000);
    tick;
    req_i = 2'b11;
    neg; chk("s3_lock_c1", master_add_o, 32'h3000);
    tick;
    neg; chk("s3_lock_c2", master_add_o, 32'h3000);
    tick;
    master_gnt_i = 1'b1; exp_g(2'b01, 32'h3000);
    tick;
    req_i = 2'b10; exp_g(2'b10, 32'h4000);
    tick;
    req_i = 2'b00; master_gnt_i = 1'b0;
    master_r_valid_i = 1'b1; master_r_rdata_i = 32'h11; exp_r(2'b01, 1'b0, 32'h11);
    tick;
    master_r_rdata_i = 32'h22; exp_r(2'b10, 1'b0, 32'h22);
    tick;
    master_r_valid_i = 1'b0;
    // outstanding limit of two
    req_i = 2'b01; master_gnt_i = 1'b1; exp_g(2'b01, 32'h3000);
    tick;
    exp_g(2'b01, 32'h3000);
    tick;
    neg; chk("s4_full", master_req_o, 0);
    tick;
    master_r_valid_i = 1'b1; master_r_rdata_i = 32'h33; exp_r(2'b01, 1'b0, 32'h33);
    neg; chk("s4_pop_same_cycle", master_req_o, 0);
    tick;
    master_r_valid_i = 1'b0; exp_g(2'b01, 32'h3000);
    neg; chk("s4_resume", master_req_o, 1);
    tick;
    req_i = 2'b00; master_gnt_i = 1'b0;
    master_r_valid_i = 1'b1; master_r_rdata_i = 32'h44; exp_r(2'b01, 1'b0, 32'h44);
    tick;
    master_r_rdata_i = 32'h55; exp_r(2'b01, 1'b0, 32'h55);
    tick;
    master_r_valid_i = 1'b0;
    // clear with one transaction in flight
    req_i = 2'b01; master_gnt_i = 1'b1; exp_g(2'b01, 32'h3000);
    tick;
    dmactive_i = 1'b0;
    neg; chk("s5_clr_req", master_req_o, 0); chk("s5_clr_gnt", gnt_o, 0);
    tick;
    dmactive_i = 1'b1; req_i = 2'b00; master_gnt_i = 1'b0;
    master_r_valid_i = 1'b1; master_r_rdata_i = 32'h66; exp_r(2'b00, 1'b1, 32'h66);
    tick;
    master_r_valid_i = 1'b0;
    neg; chk("s5_err_once", rsp_err_o, 0); chk("s5_rvalid", r_valid_o, 0);
    tick;
    req_i = 2'b01; master_gnt_i = 1'b1; exp_g(2'b01, 32'h3000);
    tick;
    exp_g(2'b01, 32'h3000);
    tick;
    neg; chk("s5_count_zero", master_req_o, 0);
    tick;
    req_i = 2'b00; master_gnt_i = 1'b0;
    // async reset while locked and outstanding
    master_r_valid_i = 1'b1; master_r_rdata_i = 32'h77; exp_r(2'b01, 1'b0, 32'h77);
    tick;
    master_r_valid_i = 1'b0; req_i = 2'b10;
    neg; chk("s6_req_pre", master_req_o, 1);
    tick;
    #1;
    rst_ni = 1'b0; master_r_valid_i = 1'b1; master_gnt_i = 1'b1; we_i = 2'b11;
    neg;
    chk("s6_rst_req", master_req_o, 0);
    chk("s6_rst_gnt", gnt_o, 0);
    chk("s6_rst_rvalid", r_valid_o, 0);
    chk("s6_rst_err", rsp_err_o, 0);
    chk("s6_rst_we", master_we_o, 0);
    tick;
    rst_ni = 1'b1; master_r_valid_i = 1'b0; we_i = 2'b00; req_i = 2'b11; exp_g(2'b01, 32'h3000);
    tick;
    req_i = 2'b00; master_gnt_i = 1'b0;
    master_r_valid_i = 1'b1; master_r_rdata_i = 32'h88; exp_r(2'b01, 1'b0, 32'h88);
    tick;
    master_r_valid_i = 1'b0;
    tick;
    chk("gnt_pending", 64'(qg.size()), 0);
    chk("rsp_pending", 64'(qr.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dm_sba_arbiter.md
Name: dm_sba_arbiter

Overview:
- Shares one system bus master port (req/gnt/r_valid, in-order responses) between NumReq requesters, e.g. the SBA engine and a debug-module memory-access engine.
- Request arbitration is round-robin with a lock while a request waits for grant.
- A small in-order ID FIFO tracks outstanding transactions and routes each response back to the requester that issued it.
- Sits between requester bus ports and the bus master port of the debug module.

Parameters:
- NumReq, 2, number of requesters (≥2).
- BusWidth, 32, address/data width (32 or 64).
- MaxOutstanding, 2, maximum accepted-but-unanswered transactions (≥1, power of 2).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous reset, active low.
- dmactive_i  in  1  synchronous clear, active low.
- req_i  in  NumReq  per-requester request.
- add_i  in  NumReq×BusWidth  per-requester address.
- we_i  in  NumReq  per-requester write enable.
- wdata_i  in  NumReq×BusWidth  per-requester write data.
- be_i  in  NumReq×BusWidth/8  per-requester byte enables.
- gnt_o  out  NumReq  per-requester grant.
- r_valid_o  out  NumReq  per-requester response valid.
- r_rdata_o  out  BusWidth  response data, broadcast to all requesters.
- master_req_o  out  1  bus request.
- master_add_o  out  BusWidth  bus address.
- master_we_o  out  1  bus write enable.
- master_wdata_o  out  BusWidth  bus write data.
- master_be_o  out  BusWidth/8  bus byte enables.
- master_gnt_i  in  1  bus grant.
- master_r_valid_i  in  1  bus response valid; returned for reads and writes, in order.
- master_r_rdata_i  in  BusWidth  bus read data.
- rsp_err_o  out  1  single-cycle pulse on a response with no outstanding entry.

Behaviour:
- Reset (rst_ni low): rr pointer=0, lock cleared, FIFO empty, count=0.
  - All outputs 0, except master_add_o/master_wdata_o/master_be_o, which follow the selected requester (requester 0 at reset).
- Clear: dmactive_i low has the same effect as reset, synchronously.
  - Forces master_req_o=0 and gnt_o=0 that cycle.
  - Responses still in flight afterwards hit an empty FIFO and raise rsp_err_o.
- full = (count == MaxOutstanding), using the registered count.
  - While full: master_req_o=0 and gnt_o=0, even if a pop happens in the same cycle.
- Selection (combinational, zero latency):
  - If lock is set, sel = locked index.
  - Else sel = first i with req_i[i]=1, searching from rr pointer upward with wrap-around.
- master_req_o = req_i[sel] & ~full & dmactive_i.
- master_add/we/wdata/be = fields of requester sel.
- gnt_o[sel] = master_gnt_i & master_req_o; all other gnt_o bits are 0.
- Lock:
  - Set, storing sel, when master_req_o=1 and master_gnt_i=0.
  - Cleared on handshake.
  - Requesters must hold req_i and their fields stable until granted; withdrawing early is illegal (assertion).
- Handshake (master_req_o & master_gnt_i):
  - Push sel into the ID FIFO.
  - rr pointer = sel+1 mod NumReq.
- Response (master_r_valid_i):
  - FIFO non-empty: pop head and set r_valid_o[head]=1 in the same cycle, combinationally. r_rdata_o = master_r_rdata_i at all times.
  - FIFO empty: r_valid_o stays 0, rsp_err_o=1 for that cycle, no state change.
- Count: +1 on push, −1 on pop, unchanged when both occur in one cycle. The count never wraps.
- Response latency: 0 cycles added. Request latency: 0 cycles added.
- Single requester active: it is served back-to-back every cycle the bus grants, up to MaxOutstanding.

Decomposition:
- Package dm gets:
  - localparam for the default MaxOutstanding.
  - typedef dm::sba_rr_idx_t, width $clog2(NumReq), parameterised in the module.
- Sub-module dm_sba_id_fifo: depth MaxOutstanding, data width $clog2(NumReq).
  - Ports: push, pop, data in/out, empty, full.
  - Flush driven by ~dmactive_i.
  - Handles simultaneous push/pop when non-empty.
- The arbiter, lock and count logic live in dm_sba_arbiter.

Test Plan:
- Single request: req_i=01, add0=0x1000, gnt after 2 cycles → master_add_o=0x1000 held steady for 3 cycles, gnt_o=01 in cycle 3; r_valid with rdata=0xDEADBEEF → r_valid_o=01, r_rdata_o=0xDEADBEEF.
- Round-robin fairness: req_i=11 constant, gnt always 1 → grants alternate 01,10,01,10. Responses after 1 cycle route in issue order.
- Lock: req_i=01 stalled without gnt, then req_i[1] rises → master fields stay on requester 0 until granted; requester 1 is granted next.
- Outstanding limit: MaxOutstanding=2, no r_valid → after 2 grants master_req_o=0. One r_valid → requests resume next cycle, not the same cycle.
- Spurious/clear: 1 outstanding, drop dmactive_i for 1 cycle, then r_valid → rsp_err_o pulses once, r_valid_o=00, count stays 0.
- Async reset mid-transaction: rst_ni low while locked and outstanding → all outputs 0. After release the first grant goes to requester 0.
